// File: rtl/nibble_word_rx.sv
// Nibble-to-word receiver: assembles LSB-first 4-bit nibbles into 32-bit words
// and presents them through a small FIFO on a valid/ready response channel.
module nibble_word_rx #(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       nib_i,
  input  logic             nib_valid_i,
  input  logic             nib_sof_i,
  output logic [31:0]      data_pdata_o,
  output logic             data_pvalid_o,
  input  logic             data_pready_i,
  output logic             overflow_o,
  input  logic             overflow_clr_i,
  output logic [2:0]       nib_cnt_o,
  output logic [LVL_W-1:0] level_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef enum logic {COLLECT, COMPLETE} phase_e;

  phase_e             phase;
  logic [2:0]         nib_cnt_q, nib_cnt_d;
  logic [31:0]        shift_q, shift_d;
  logic [31:0]        word;
  logic [31:0]        mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               ovf_q, ovf_d;
  logic               pop, full, do_push, drop;

  assign word = {nib_i, shift_q[31:4]};

  // SOF takes priority: a restarting nibble never completes a word.
  always_comb begin
    phase = COLLECT;
    if (nib_valid_i && !nib_sof_i && nib_cnt_q == 3'd7) phase = COMPLETE;
  end

  always_comb begin
    shift_d   = shift_q;
    nib_cnt_d = nib_cnt_q;
    if (nib_valid_i) begin
      if (nib_sof_i) begin
        shift_d   = {nib_i, 28'h0};
        nib_cnt_d = 3'd1;
      end else begin
        shift_d   = word;
        nib_cnt_d = nib_cnt_q + 3'd1;
      end
    end
  end

  always_comb begin
    pop     = (level_q != '0) && data_pready_i;
    full    = (level_q == LVL_W'(DEPTH));
    do_push = (phase == COMPLETE) && (!full || pop);
    drop    = (phase == COMPLETE) && full && !pop;
    level_d = level_q + LVL_W'(do_push) - LVL_W'(pop);
    ovf_d   = ovf_q;
    if (overflow_clr_i) ovf_d = 1'b0;
    if (drop)           ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nib_cnt_q <= '0;
      shift_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      nib_cnt_q <= nib_cnt_d;
      shift_q   <= shift_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // Storage needs no reset; an empty FIFO forces the output to zero.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr_q] <= word;
  end

  assign data_pvalid_o = (level_q != '0);
  assign data_pdata_o  = data_pvalid_o ? mem[rd_ptr_q] : '0;
  assign overflow_o    = ovf_q;
  assign nib_cnt_o     = nib_cnt_q;
  assign level_o       = level_q;

endmodule

// File: doc/nibble_word_rx.md
Name: nibble_word_rx

Overview:
- Receive-side counterpart of the core's 32-bit-to-4-bit data serializer.
- Assembles 4-bit nibbles, strobed in from the dedicated input pins, into 32-bit words. LSB nibble first, 8 nibbles per word.
- Buffers completed words in a small FIFO.
- Presents buffered words to the Snitch data response channel (data_pdata/data_pvalid/data_pready) with valid/ready semantics.

Parameters:
- DEPTH, 2, word FIFO entries; power of two, >= 2.
- LVL_W, $clog2(DEPTH)+1, width of the fill-level output (derived; not overridden).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- nib_i  input  4  incoming nibble.
- nib_valid_i  input  1  nib_i is sampled on every cycle this is high.
- nib_sof_i  input  1  qualified by nib_valid_i; marks the current nibble as nibble 0 of a new word.
- data_pdata_o  output  32  head word of the FIFO.
- data_pvalid_o  output  1  FIFO not empty.
- data_pready_i  input  1  consumer accepts the head word.
- overflow_o  output  1  sticky; a completed word was dropped.
- overflow_clr_i  input  1  clears overflow_o.
- nib_cnt_o  output  3  nibbles collected in the current partial word.
- level_o  output  LVL_W  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: rst is synchronous and active-high. While rst is high at a rising clk edge, clear:
  - nib_cnt, shift register, FIFO pointers, level, overflow.
  - Outputs: data_pvalid_o=0, data_pdata_o=0 (empty FIFO forces zero), overflow_o=0, nib_cnt_o=0, level_o=0.
  - A reset mid-word discards the partial word. A reset with a full FIFO discards all stored words.
- Assembler FSM, two states:
  - COLLECT: nib_cnt 0..6.
  - COMPLETE: the 8th nibble is accepted this cycle (combinational qualifier on nib_cnt==7 && nib_valid_i).
  - Implemented as a 3-bit counter plus a 32-bit shift register.
- Nibble accept: on nib_valid_i, shift_d = {nib_i, shift_q[31:4]} and nib_cnt increments mod 8. Cycles with nib_valid_i=0 change nothing.
- SOF: nib_valid_i && nib_sof_i:
  - discard the partial word;
  - the nibble becomes nibble 0 and nib_cnt becomes 1;
  - no overflow is flagged for the discarded partial word.
- SOF when nib_cnt==0: no effect beyond normal acceptance.
- Word completion: when nib_cnt==7 and nib_valid_i (and no SOF), the word {nib_i, shift_q[31:4]} is pushed this cycle and nib_cnt returns to 0.
- Result ordering: the word equals n7..n0, with n0 in bits [3:0].
- Latency: data_pvalid_o rises the cycle after the edge that samples the 8th nibble, if the FIFO was empty.
- Output handshake:
  - data_pvalid_o = (level != 0); data_pdata_o = head entry.
  - Pop on data_pvalid_o && data_pready_i.
  - data_pdata_o is stable while data_pvalid_o=1 and no pop occurs.
  - data_pready_i while empty is ignored.
- Full FIFO with a word completing:
  - with a pop in the same cycle: push succeeds, level unchanged;
  - without a pop: the word is dropped, overflow_o is set on the next cycle, and the FIFO contents are unchanged.
- Simultaneous push and pop at any level: level unchanged, FIFO order preserved.
- Pointers are log2(DEPTH) bits and wrap naturally; level is tracked separately.
- overflow_clr_i:
  - clears overflow_o next cycle;
  - if a drop occurs in the same cycle, set wins.
- Words are never reordered or duplicated. Partial words are never pushed.

Test Plan:
- Reset, then nibbles 1,2,3,4,5,6,7,8 on consecutive cycles with pready=1 -> one cycle after the 8th nibble: pvalid=1, pdata=0x87654321; popped the same cycle; level returns to 0.
- Nibbles 0xF,0xE,0xD,0xC,0xB,0xA,0x9,0x0 with nib_valid_i gapped every other cycle, pready=0 -> pdata=0x09ABCDEF, held stable for 10 cycles; pops on the first pready=1 cycle.
- DEPTH=2, pready=0, three words 0x11111111, 0x22222222, 0x33333333 -> level=2, overflow_o=1, third word lost. Then pready=1 -> outputs 0x11111111 then 0x22222222, then pvalid=0. overflow_clr_i -> overflow_o=0.
- FIFO full, 8th nibble of 0x44444444 arrives in the same cycle as a pop -> no overflow; level stays 2; later output order is 0x22222222, 0x44444444.
- Three nibbles 0xA, then SOF with 0x1 followed by 2..8 -> pdata=0x87654321, nib_cnt_o=0 afterwards, overflow_o=0.
- Five nibbles sent, rst pulsed one cycle mid-word with one word stored -> pvalid=0, level=0, nib_cnt_o=0. The next 8 nibbles 0..7 produce 0x76543210.
